multiplier_8bit_seq: RTL and testbench

Sequential 8x8 unsigned multiplier that time-multiplexes one combinational multiplier_4bit over four nibble partial products. The block sits directly downstream of multiplier_4bit: it selects the nibble operands, consumes the 8-bit product and shift-accumulates it into a 16-bit result. It trades area for latency against the fully parallel four-instance 8x8 array. It uses a start/busy/done handshake for the surrounding datapath.

---
 rtl/mult_pkg.sv | 23 ++
 rtl/multiplier_4bit.sv | 10 +
 rtl/multiplier_8bit_seq.sv | 108 ++++++++++
 tb/tb_multiplier_8bit_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the nibble-serial 8x8 multiplier.
// Holds the FSM encodings, operand widths, step indices and per-step shift amounts.
package mult_pkg;

    localparam int unsigned NIB_W = 4;
    localparam int unsigned OP_W  = 8;

    typedef enum logic {IDLE, MUL} state_t;

    // Sub-phase of MUL, only meaningful when the partial product is registered
    typedef enum logic {PH_SEL, PH_ACC} phase_t;

    typedef logic [1:0] step_t;

    localparam step_t STEP_LL = 2'd0;
    localparam step_t STEP_HL = 2'd1;
    localparam step_t STEP_LH = 2'd2;
    localparam step_t STEP_HH = 2'd3;

    // Indexed by step: LL=0, HL=4, LH=4, HH=8
    localparam logic [3:0][3:0] SHIFT_TBL = {4'd8, 4'd4, 4'd4, 4'd0};

endpackage

// File: rtl/multiplier_4bit.sv
// Combinational 4x4 unsigned multiplier producing an 8-bit product.
module multiplier_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] result
);

    assign result = {4'b0000, a} * {4'b0000, b};

endmodule

// File: rtl/multiplier_8bit_seq.sv
// Sequential 8x8 unsigned multiplier: one shared 4x4 multiplier walks the four
// nibble partial products and shift-accumulates them into a 16-bit result.
module multiplier_8bit_seq
    import mult_pkg::*;
#(
    parameter int unsigned PP_REG = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [15:0]     result
);

    state_t               state;
    state_t               state_next;
    phase_t               phase;
    step_t                step;
    logic [OP_W-1:0]      a_r;
    logic [OP_W-1:0]      b_r;
    logic [15:0]          acc;
    logic [15:0]          acc_sum;
    logic [NIB_W-1:0]     a_nib;
    logic [NIB_W-1:0]     b_nib;
    logic [2*NIB_W-1:0]   pp;
    logic [2*NIB_W-1:0]   pp_r;
    logic [2*NIB_W-1:0]   pp_src;
    logic                 accept;
    logic                 sel_en;
    logic                 acc_en;
    logic                 last;

    multiplier_4bit u_mul4 (a_nib, b_nib, pp);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = MUL;
            MUL:     if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With PP_REG=1 each step spends one edge capturing pp and one accumulating it
    always_comb begin
        accept = (state == IDLE) && start;
        sel_en = (state == MUL) && (PP_REG != 0) && (phase == PH_SEL);
        acc_en = (state == MUL) && ((PP_REG == 0) || (phase == PH_ACC));
        last   = acc_en && (step == STEP_HH);
    end

    always_comb begin
        a_nib   = ((step == STEP_LL) || (step == STEP_LH)) ? a_r[NIB_W-1:0] : a_r[OP_W-1:NIB_W];
        b_nib   = ((step == STEP_LL) || (step == STEP_HL)) ? b_r[NIB_W-1:0] : b_r[OP_W-1:NIB_W];
        pp_src  = (PP_REG != 0) ? pp_r : pp;
        acc_sum = acc + ({{OP_W{1'b0}}, pp_src} << SHIFT_TBL[step]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            step   <= STEP_LL;
            phase  <= PH_SEL;
            pp_r   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_r   <= a;
                b_r   <= b;
                acc   <= '0;
                step  <= STEP_LL;
                phase <= PH_SEL;
                busy  <= 1'b1;
            end
            if (sel_en) begin
                pp_r  <= pp;
                phase <= PH_ACC;
            end
            if (acc_en) begin
                acc   <= acc_sum;
                step  <= step + 2'd1;
                phase <= PH_SEL;
                if (last) begin
                    result <= acc_sum;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_multiplier_8bit_seq.sv
// Directed bench for multiplier_8bit_seq: one instance per PP_REG setting,
// a vector table for products and latency, plus hand-written handshake sequences.
module tb_multiplier_8bit_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0;
    logic        start1;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        busy0, done0, busy1, done1;
    logic [15:0] res0, res1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    multiplier_8bit_seq #(.PP_REG(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .a(a_in), .b(b_in),
        .busy(busy0), .done(done0), .result(res0)
    );

    multiplier_8bit_seq #(.PP_REG(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a_in), .b(b_in),
        .busy(busy1), .done(done1), .result(res1)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic busy_of(input int unsigned sel);
        return (sel != 0) ? busy1 : busy0;
    endfunction

    function automatic logic done_of(input int unsigned sel);
        return (sel != 0) ? done1 : done0;
    endfunction

    function automatic logic [15:0] res_of(input int unsigned sel);
        return (sel != 0) ? res1 : res0;
    endfunction

    // Starts one operation, scrambles a/b after acceptance, measures latency and busy width
    task automatic run_op(input int unsigned sel, input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] exp, input int unsigned exp_lat, input string tag);
        int unsigned lat;
        int unsigned busy_cnt;
        @(negedge clk);
        a_in = x;
        b_in = y;
        if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        a_in = ~x;
        b_in = y ^ 8'h5A;
        lat = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            if (busy_of(sel)) busy_cnt++;
            @(negedge clk);
            if (done_of(sel)) lat = k;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy cycles"}, busy_cnt, exp_lat);
        check({tag, " result"}, res_of(sel), exp);
        check({tag, " busy low at done"}, busy_of(sel), 1'b0);
        @(negedge clk);
        check({tag, " done single pulse"}, done_of(sel), 1'b0);
        check({tag, " result held"}, res_of(sel), exp);
    endtask

    initial begin
        int unsigned dones;
        int unsigned first_done;
        logic [15:0] seen;

        vecs[0] = '{a: 8'd3,   b: 8'd5,   exp: 16'h000F};
        vecs[1] = '{a: 8'hA6,  b: 8'h3C,  exp: 16'h26E8};
        vecs[2] = '{a: 8'hFF,  b: 8'hFF,  exp: 16'hFE01};
        vecs[3] = '{a: 8'h00,  b: 8'h09,  exp: 16'h0000};
        vecs[4] = '{a: 8'h80,  b: 8'h02,  exp: 16'h0100};
        vecs[5] = '{a: 8'd5,   b: 8'd6,   exp: 16'h001E};
        vecs[6] = '{a: 8'd12,  b: 8'd12,  exp: 16'h0090};
        vecs[7] = '{a: 8'd200, b: 8'd3,   exp: 16'h0258};

        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        a_in = '0;
        b_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset busy0", busy0, 1'b0);
        check("reset done0", done0, 1'b0);
        check("reset result0", res0, 16'h0000);
        check("reset busy1", busy1, 1'b0);
        check("reset result1", res1, 16'h0000);

        for (int i = 0; i < 8; i++) begin
            run_op(0, vecs[i].a, vecs[i].b, vecs[i].exp, 4, $sformatf("pp0 vec%0d", i));
            run_op(1, vecs[i].a, vecs[i].b, vecs[i].exp, 8, $sformatf("pp1 vec%0d", i));
        end

        // 7*9 with a second start pulse while busy and operands changing mid-flight
        @(negedge clk);
        a_in = 8'd7;
        b_in = 8'd9;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        dones = 0;
        first_done = 0;
        seen = '0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 1) begin
                a_in = 8'd2;
                b_in = 8'd2;
                start0 = 1'b1;
            end else if (k == 2) begin
                start0 = 1'b0;
                a_in = 8'h55;
                b_in = 8'hAA;
            end
            @(negedge clk);
            if (done0) begin
                dones++;
                if (first_done == 0) begin
                    first_done = k;
                    seen = res0;
                end
            end
        end
        check("ignore-start done count", dones, 1);
        check("ignore-start latency", first_done, 4);
        check("ignore-start result", seen, 16'h003F);
        check("ignore-start result held", res0, 16'h003F);

        // Back-to-back: second start issued in the done cycle of the first
        @(negedge clk);
        a_in = 8'd12;
        b_in = 8'd12;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        first_done = 0;
        for (int k = 1; k <= 20 && first_done == 0; k++) begin
            @(negedge clk);
            if (done0) first_done = k;
        end
        check("b2b first latency", first_done, 4);
        check("b2b first result", res0, 16'h0090);
        a_in = 8'd200;
        b_in = 8'd3;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("b2b no bubble busy", busy0, 1'b1);
        first_done = 0;
        for (int k = 1; k <= 20 && first_done == 0; k++) begin
            @(negedge clk);
            if (done0) first_done = k;
        end
        check("b2b second latency", first_done, 4);
        check("b2b second result", res0, 16'h0258);

        // Reset in the middle of 200*200 clears everything without a done pulse
        run_op(0, 8'd5, 8'd6, 16'h001E, 4, "pre-reset 5x6");
        @(negedge clk);
        a_in = 8'd200;
        b_in = 8'd200;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        dones = 0;
        repeat (2) begin
            @(negedge clk);
            if (done0) dones++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", busy0, 1'b0);
        check("abort done", done0, 1'b0);
        check("abort result", res0, 16'h0000);
        repeat (8) begin
            @(negedge clk);
            if (done0) dones++;
        end
        check("abort no done", dones, 0);
        check("abort result stays", res0, 16'h0000);
        run_op(0, 8'd5, 8'd6, 16'h001E, 4, "post-reset 5x6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
